data_mem_arbiter: RTL and testbench

//  Two-requester arbiter sharing the single-port DataMemory between the CORE data port (req0)
//  and a loader/DMA port (req1). Round-robin with a bounded burst length so neither side starves.

---
 rtl/data_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the core data port (req0)
// and a loader/DMA port (req1). Round-robin ownership with a bounded burst so a continuously
// requesting owner hands over after MAX_BURST accepts when the other side is waiting.
// Grants and memory controls are combinational from the registered owner state; ack and read
// data are registered one cycle after each accepted transfer.
module data_mem_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // Burst counter needs at least one bit even when MAX_BURST is 1.
   localparam int unsigned BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_BURST - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  last_q, last_d;
   logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

   // Ownership FSM: tie-break on last owner, hand over when burst limit hit under contention.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         ST_IDLE: begin
            bcnt_d = '0;
            if (req0 && req1) begin
               state_d = last_q ? ST_OWN0 : ST_OWN1;
            end else if (req0) begin
               state_d = ST_OWN0;
            end else if (req1) begin
               state_d = ST_OWN1;
            end
         end
         ST_OWN0: begin
            if (!req0) begin
               state_d = req1 ? ST_OWN1 : ST_IDLE;
               bcnt_d  = '0;
               last_d  = 1'b0;
            end else if (!req1) begin
               if (bcnt_q != BCNT_MAX) bcnt_d = bcnt_q + 1'b1;
            end else if (bcnt_q == BCNT_MAX) begin
               state_d = ST_OWN1;
               bcnt_d  = '0;
               last_d  = 1'b0;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         ST_OWN1: begin
            if (!req1) begin
               state_d = req0 ? ST_OWN0 : ST_IDLE;
               bcnt_d  = '0;
               last_d  = 1'b1;
            end else if (!req0) begin
               if (bcnt_q != BCNT_MAX) bcnt_d = bcnt_q + 1'b1;
            end else if (bcnt_q == BCNT_MAX) begin
               state_d = ST_OWN0;
               bcnt_d  = '0;
               last_d  = 1'b1;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
         end
      endcase
   end

   // Grants and memory-side mux; a write strobe needs a grant and is suppressed under reset.
   always_comb begin
      gnt0      = (state_q == ST_OWN0) && req0;
      gnt1      = (state_q == ST_OWN1) && req1;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      case (state_q)
         ST_OWN0: begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = req0 && we0 && !reset;
         end
         ST_OWN1: begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = req1 && we1 && !reset;
         end
         default: ;
      endcase
   end

   // Response path: ack one cycle after accept, read data captured only on accepted reads.
   always_comb begin
      ack0_d   = gnt0;
      ack1_d   = gnt1;
      rdata0_d = (gnt0 && !we0) ? mem_rdata : rdata0_q;
      rdata1_d = (gnt1 && !we1) ? mem_rdata : rdata1_q;
   end

   // State and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         last_q   <= 1'b1;
         bcnt_q   <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         bcnt_q   <= bcnt_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with per-cycle expected grants; accepted
// transfers push the expected ack/data into a queue that is popped when the ack is due.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        gnt0, gnt1, ack0, ack1, mem_we;
   logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

   data_mem_arbiter #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .MAX_BURST (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0),
      .we0      (we0),
      .addr0    (addr0),
      .wdata0   (wdata0),
      .req1     (req1),
      .we1      (we1),
      .addr1    (addr1),
      .wdata1   (wdata1),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .ack0     (ack0),
      .ack1     (ack1),
      .rdata0   (rdata0),
      .rdata1   (rdata1),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write on rising edge.
   logic [31:0] mem [0:63];
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
   end

   typedef struct {
      int          who;
      logic        is_read;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] shadow [0:63];
   logic [31:0] exp_rd0, exp_rd1;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   // One bus cycle with current inputs: check responses due now, grants, memory side; advance.
   task automatic tick(input logic eg0, input logic eg1);
      exp_t e;
      logic exp_we;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq("ack0", {31'd0, ack0}, (e.who == 0) ? 32'd1 : 32'd0);
         check_eq("ack1", {31'd0, ack1}, (e.who == 1) ? 32'd1 : 32'd0);
         if (e.is_read) begin
            if (e.who == 0) exp_rd0 = e.data;
            else exp_rd1 = e.data;
         end
      end else begin
         check_eq("ack0_idle", {31'd0, ack0}, 32'd0);
         check_eq("ack1_idle", {31'd0, ack1}, 32'd0);
      end
      check_eq("rdata0", rdata0, exp_rd0);
      check_eq("rdata1", rdata1, exp_rd1);
      check_eq("gnt0", {31'd0, gnt0}, {31'd0, eg0});
      check_eq("gnt1", {31'd0, gnt1}, {31'd0, eg1});
      exp_we = !reset && ((eg0 && we0) || (eg1 && we1));
      check_eq("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (eg0) begin
         check_eq("mem_addr0", mem_addr, addr0);
         if (we0) check_eq("mem_wdata0", mem_wdata, wdata0);
      end
      if (eg1) begin
         check_eq("mem_addr1", mem_addr, addr1);
         if (we1) check_eq("mem_wdata1", mem_wdata, wdata1);
      end
      if (!reset) begin
         if (eg0) begin
            sb.push_back('{0, !we0, we0 ? 32'd0 : shadow[addr0[7:2]]});
            if (we0) shadow[addr0[7:2]] = wdata0;
         end
         if (eg1) begin
            sb.push_back('{1, !we1, we1 ? 32'd0 : shadow[addr1[7:2]]});
            if (we1) shadow[addr1[7:2]] = wdata1;
         end
      end
      @(posedge clk);
      #1;
      if (reset) begin
         exp_rd0 = '0;
         exp_rd1 = '0;
         sb.delete();
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]    = 32'h0101_0101 * i;
         shadow[i] = 32'h0101_0101 * i;
      end
      mem[2]    = 32'hDEAD_BEEF;
      shadow[2] = 32'hDEAD_BEEF;
      exp_rd0 = '0;
      exp_rd1 = '0;
      reset = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      repeat (2) @(posedge clk);
      #1;
      tick(1'b0, 1'b0);
      reset = 1'b0;

      // Single read after reset: grant one cycle after request, ack the cycle after.
      req0 = 1'b1; addr0 = 32'h8;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      req0 = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);

      // Contention from IDLE after reset: 4/4 bursts, no bubble at handover.
      reset = 1'b1;
      tick(1'b0, 1'b0);
      reset = 1'b0;
      req0 = 1'b1; addr0 = 32'h0;
      req1 = 1'b1; addr1 = 32'h4;
      tick(1'b0, 1'b0);
      repeat (4) tick(1'b1, 1'b0);
      repeat (4) tick(1'b0, 1'b1);
      repeat (2) tick(1'b1, 1'b0);
      req0 = 1'b0; req1 = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);

      // Loader writes, then core reads the same word back.
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h10; wdata1 = 32'h1234_5678;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      req1 = 1'b0; we1 = 1'b0;
      req0 = 1'b1; addr0 = 32'h10;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      req0 = 1'b0;
      tick(1'b0, 1'b0);

      // Long solo burst saturates the counter; a late req1 still gets the next cycle.
      req0 = 1'b1; addr0 = 32'h8;
      tick(1'b0, 1'b0);
      repeat (10) tick(1'b1, 1'b0);
      req1 = 1'b1; addr1 = 32'h10;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      req0 = 1'b0; req1 = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);

      // Owner drops mid-burst: IDLE next, so a fresh request waits a cycle again.
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hA5A5_A5A5;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      req1 = 1'b0;
      tick(1'b0, 1'b0);
      req1 = 1'b1;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      req1 = 1'b0; we1 = 1'b0;
      tick(1'b0, 1'b0);

      // Reset during an accepted read drops its ack and clears rdata.
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      reset = 1'b1;
      tick(1'b1, 1'b0);
      reset = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      // Write granted while reset is high must not reach memory.
      we0 = 1'b1; wdata0 = 32'hFFFF_0000;
      reset = 1'b1;
      tick(1'b1, 1'b0);
      reset = 1'b0; we0 = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      req0 = 1'b0;
      tick(1'b0, 1'b0);
      check_eq("sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
